// File: rtl/LLSSineReconstruction_hls_deadlock_pkg.sv
// Shared FSM encoding for the deadlock report unit.
// States: IDLE, ORIGIN, TRACE, REPORT.
package LLSSineReconstruction_hls_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ORIGIN = 2'd1,
    TRACE  = 2'd2,
    REPORT = 2'd3
  } dl_state_e;

endpackage

// File: rtl/LLSSineReconstruction_hls_deadlock_prio_enc.sv
// Lowest-set-bit priority encoder.
// i_vec: request bits; o_idx: lowest set index; o_any: any bit set.
module LLSSineReconstruction_hls_deadlock_prio_enc #(
  parameter int PROC_NUM = 4,
  parameter int IDX_W    = 2
) (
  input  logic [PROC_NUM-1:0] i_vec,
  output logic [IDX_W-1:0]    o_idx,
  output logic                o_any
);

  always_comb begin
    o_idx = '0;
    o_any = |i_vec;
    // Scan downwards so the lowest set bit is written last and wins.
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/llssinereconstruction_hls_deadlock_report_unit.sv
// Deadlock report unit: picks an origin, traces its token, reports the path.
// In: clock, reset, dl_in_vec, token_vec, report_ack. Out: origin_vec,
// token_clear, dl_detect, report_vld, dl_origin_idx, dl_path, dl_timeout,
// dl_cycle.
module llssinereconstruction_hls_deadlock_report_unit
  import LLSSineReconstruction_hls_deadlock_pkg::*;
#(
  parameter int PROC_NUM  = 4,
  parameter int IDX_W     = 2,
  parameter int TRACE_MAX = 16,
  parameter int CNT_W     = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  input  logic [PROC_NUM-1:0] token_vec,
  input  logic                report_ack,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                token_clear,
  output logic                dl_detect,
  output logic                report_vld,
  output logic [IDX_W-1:0]    dl_origin_idx,
  output logic [PROC_NUM-1:0] dl_path,
  output logic                dl_timeout,
  output logic [CNT_W-1:0]    dl_cycle
);

  localparam int TW = (TRACE_MAX > 2) ? $clog2(TRACE_MAX) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TRACE_MAX - 1);

  dl_state_e           r_state;
  dl_state_e           w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [TW-1:0]       r_timer;
  logic [IDX_W-1:0]    r_idx;
  logic [PROC_NUM-1:0] r_path;
  logic [CNT_W-1:0]    r_cycle;
  logic                r_timeout;
  logic                r_detect;
  logic                r_clr;
  logic [IDX_W-1:0]    w_idx;
  logic                w_any;
  logic                w_ret;
  logic                w_tmo;

  LLSSineReconstruction_hls_deadlock_prio_enc #(
    .PROC_NUM (PROC_NUM),
    .IDX_W    (IDX_W)
  ) u_prio (
    .i_vec (dl_in_vec),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_next = r_state;
    w_ret  = 1'b0;
    w_tmo  = 1'b0;
    unique case (r_state)
      IDLE:   if (w_any) w_next = ORIGIN;
      ORIGIN: w_next = TRACE;
      TRACE: begin
        // Timer 0 is the cycle the origin injected its token; ignore it.
        w_ret = (r_timer != '0) && token_vec[r_idx];
        w_tmo = (r_timer == T_LAST);
        if (w_ret || w_tmo) w_next = REPORT;
      end
      REPORT: if (report_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_timer   <= '0;
      r_idx     <= '0;
      r_path    <= '0;
      r_cycle   <= '0;
      r_timeout <= 1'b0;
      r_detect  <= 1'b0;
      r_clr     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_clr   <= 1'b0;
      if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_idx    <= w_idx;
            r_cycle  <= r_cnt;
            r_path   <= '0;
            r_detect <= 1'b1;
          end
        end
        ORIGIN: r_timer <= '0;
        TRACE: begin
          r_path  <= r_path | token_vec;
          r_timer <= r_timer + TW'(1);
          if (w_ret || w_tmo) begin
            r_clr     <= 1'b1;
            r_timeout <= ~w_ret;
          end
        end
        default: ;
      endcase
    end
  end

  assign origin_vec    = (r_state == ORIGIN) ?
                         (PROC_NUM'(1) << r_idx) : '0;
  assign token_clear   = r_clr;
  assign dl_detect     = r_detect;
  assign report_vld    = (r_state == REPORT);
  assign dl_origin_idx = r_idx;
  assign dl_path       = r_path;
  assign dl_timeout    = r_timeout;
  assign dl_cycle      = r_cycle;

endmodule

// File: tb/tb_llssinereconstruction_hls_deadlock_report_unit.sv
// Directed bench for the deadlock report unit.
// Second instance uses a 4-bit counter to exercise saturation.
module tb_llssinereconstruction_hls_deadlock_report_unit;

  logic        clk;
  logic        rst;
  logic [3:0]  dl_in;
  logic [3:0]  tok;
  logic        ack;
  logic [3:0]  org;
  logic        clr;
  logic        det;
  logic        vld;
  logic [1:0]  idx;
  logic [3:0]  path;
  logic        tmo;
  logic [31:0] cyc;

  logic [3:0]  dl2;
  logic [3:0]  tok2;
  logic        ack2;
  logic [3:0]  org2;
  logic        clr2;
  logic        det2;
  logic        vld2;
  logic [1:0]  idx2;
  logic [3:0]  path2;
  logic        tmo2;
  logic [3:0]  cyc2;

  int n_vec;
  int n_err;

  llssinereconstruction_hls_deadlock_report_unit dut (
    .clock         (clk),
    .reset         (rst),
    .dl_in_vec     (dl_in),
    .token_vec     (tok),
    .report_ack    (ack),
    .origin_vec    (org),
    .token_clear   (clr),
    .dl_detect     (det),
    .report_vld    (vld),
    .dl_origin_idx (idx),
    .dl_path       (path),
    .dl_timeout    (tmo),
    .dl_cycle      (cyc)
  );

  llssinereconstruction_hls_deadlock_report_unit #(
    .CNT_W (4)
  ) dut_sat (
    .clock         (clk),
    .reset         (rst),
    .dl_in_vec     (dl2),
    .token_vec     (tok2),
    .report_ack    (ack2),
    .origin_vec    (org2),
    .token_clear   (clr2),
    .dl_detect     (det2),
    .report_vld    (vld2),
    .dl_origin_idx (idx2),
    .dl_path       (path2),
    .dl_timeout    (tmo2),
    .dl_cycle      (cyc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    dl_in = '0;
    tok   = '0;
    ack   = 1'b0;
    dl2   = '0;
    tok2  = '0;
    ack2  = 1'b0;
    tick();
    tick();
    chk("rst_org",  32'(org),  0);
    chk("rst_clr",  32'(clr),  0);
    chk("rst_det",  32'(det),  0);
    chk("rst_vld",  32'(vld),  0);
    chk("rst_cyc",  cyc,       0);
    chk("rst_path", 32'(path), 0);
    rst = 1'b0;

    // Token return: detect at counter 10.
    repeat (10) tick();
    dl_in = 4'b0100;
    tick();
    chk("ret_org", 32'(org), 32'h4);
    chk("ret_det", 32'(det), 1);
    chk("ret_clr0", 32'(clr), 0);
    dl_in = '0;
    tick();
    chk("ret_org_off", 32'(org), 0);
    tok = 4'b0100;
    tick();
    tok = 4'b1000;
    tick();
    chk("ret_noclr", 32'(clr), 0);
    tok = 4'b0100;
    tick();
    chk("ret_clr",  32'(clr),  1);
    chk("ret_vld",  32'(vld),  1);
    chk("ret_idx",  32'(idx),  2);
    chk("ret_path", 32'(path), 32'hC);
    chk("ret_cyc",  cyc,       10);
    chk("ret_tmo",  32'(tmo),  0);
    tok = '0;
    tick();
    chk("ret_clr_1cyc", 32'(clr), 0);
    chk("ret_vld_hold", 32'(vld), 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ret_idle_vld", 32'(vld), 0);
    chk("ret_det_stk",  32'(det), 1);

    // Priority, then timeout with token never returning.
    dl_in = 4'b1010;
    tick();
    chk("pri_org", 32'(org), 32'h2);
    chk("pri_idx", 32'(idx), 1);
    dl_in = '0;
    tick();
    for (int k = 0; k < 16; k++) begin
      chk("tmo_wait", 32'(clr), 0);
      tick();
    end
    chk("tmo_clr",  32'(clr),  1);
    chk("tmo_flag", 32'(tmo),  1);
    chk("tmo_vld",  32'(vld),  1);
    chk("tmo_path", 32'(path), 0);

    // Pending detection held through REPORT.
    dl_in = 4'b0001;
    tick();
    tick();
    chk("ack_vld_hold", 32'(vld), 1);
    chk("ack_org_ign",  32'(org), 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_idle", 32'(vld), 0);
    tick();
    chk("ack_new_org", 32'(org), 32'h1);
    chk("ack_det",     32'(det), 1);
    chk("ack_path0",   32'(path), 0);
    dl_in = '0;
    tick();

    // Reset in the middle of a trace.
    tok = 4'b0010;
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_org",  32'(org),  0);
    chk("mrst_clr",  32'(clr),  0);
    chk("mrst_det",  32'(det),  0);
    chk("mrst_vld",  32'(vld),  0);
    chk("mrst_tmo",  32'(tmo),  0);
    chk("mrst_idx",  32'(idx),  0);
    chk("mrst_path", 32'(path), 0);
    chk("mrst_cyc",  cyc,       0);
    rst = 1'b0;
    tok = '0;
    tick();
    chk("mrst_noclr", 32'(clr), 0);

    // Return and timeout coincide: return wins.
    dl_in = 4'b0001;
    tick();
    dl_in = '0;
    tick();
    repeat (15) tick();
    tok = 4'b0001;
    tick();
    chk("tie_clr", 32'(clr), 1);
    chk("tie_tmo", 32'(tmo), 0);
    chk("tie_vld", 32'(vld), 1);
    tok = '0;
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // 4-bit counter is at cycle 20 here, saturated.
    dl2 = 4'b0001;
    tick();
    chk("sat_cyc", 32'(cyc2), 32'hF);
    chk("sat_det", 32'(det2), 1);
    dl2 = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
